// File: rtl/mem_decoder.sv
// mem_decoder: decodes a CPU access into one of NREG address regions.
// Each region can insert its own number of wait states and can be
// read-only or writable. Unmapped accesses and writes to read-only
// regions still complete normally, and the first one is recorded in
// a sticky error flag plus its address.
module mem_decoder #(
  parameter int                 AW       = 16,
  parameter int                 DW       = 8,
  parameter int                 NREG     = 2,
  parameter logic [NREG*AW-1:0] REG_BASE = {16'hB000, 16'hE000},
  parameter logic [NREG*AW-1:0] REG_MASK = {16'hF000, 16'hE000},
  parameter logic [NREG*4-1:0]  REG_WAIT = {4'd0, 4'd2},
  parameter logic [NREG-1:0]    REG_WR   = 2'b10,
  parameter logic [DW-1:0]      DEF_DATA = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [AW-1:0]      cpu_addr,
  input  logic [DW-1:0]      cpu_wdata,
  output logic [DW-1:0]      cpu_rdata,
  output logic               cpu_ready,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [NREG-1:0]    mem_sel,
  output logic [NREG-1:0]    mem_we,
  input  logic [NREG*DW-1:0] mem_rdata,
  output logic               err,
  output logic [AW-1:0]      err_addr
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [RW-1:0]   region_q, region_d;
  logic            mapped_q, mapped_d;
  logic            we_q, we_d;
  logic            ready_q, ready_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic [NREG-1:0] mem_we_q, mem_we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;

  // Address decode results for the request currently on the CPU bus
  logic [NREG-1:0] hit;
  logic            hit_any;
  logic [RW-1:0]   hit_idx;
  logic [NREG-1:0] hit_onehot;
  logic            fault;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_hit
      assign hit[gi] = (cpu_addr & REG_MASK[gi*AW +: AW]) == REG_BASE[gi*AW +: AW];
    end
  endgenerate

  // Priority select: scan from the top so the lowest matching region wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int r = NREG - 1; r >= 0; r--) begin
      if (hit[r]) begin
        hit_any = 1'b1;
        hit_idx = RW'(r);
      end
    end
  end

  assign hit_onehot = hit_any ? (NREG'(1) << hit_idx) : '0;
  // Unmapped access, or a write aimed at a read-only region
  assign fault      = !hit_any || (cpu_we && !REG_WR[hit_idx]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, leave BUSY once the wait count is spent
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch on accept, count down, complete
  always_comb begin
    cnt_d      = cnt_q;
    region_d   = region_q;
    mapped_d   = mapped_q;
    we_d       = we_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    sel_d      = sel_q;
    mem_we_d   = '0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d   = cpu_addr;
          wdata_d  = cpu_wdata;
          sel_d    = hit_onehot;
          cnt_d    = hit_any ? REG_WAIT[hit_idx*4 +: 4] : 4'd0;
          region_d = hit_idx;
          mapped_d = hit_any;
          we_d     = cpu_we;
          // Write strobe only reaches a mapped, writable region
          if (cpu_we && hit_any && REG_WR[hit_idx]) mem_we_d = hit_onehot;
          // Only the first fault is recorded until reset
          if (fault && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = cpu_addr;
          end
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          sel_d   = '0;
          // Writes leave the previously returned read data untouched
          if (!we_q) rdata_d = mapped_q ? mem_rdata[region_q*DW +: DW] : DEF_DATA;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      region_q   <= '0;
      mapped_q   <= 1'b0;
      we_q       <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      sel_q      <= '0;
      mem_we_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      region_q   <= region_d;
      mapped_q   <= mapped_d;
      we_q       <= we_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      sel_q      <= sel_d;
      mem_we_q   <= mem_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_sel   = sel_q;
  assign mem_we    = mem_we_q;
  assign err       = err_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_decoder.sv
// Testbench for mem_decoder with default parameters: a driver issues
// directed and random accesses and pushes expectations into a queue,
// a monitor pops and checks each completion.
module tb_mem_decoder;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [1:0]  mem_sel;
  logic [1:0]  mem_we;
  logic [15:0] mem_rdata;
  logic        err;
  logic [15:0] err_addr;

  mem_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_sel   (mem_sel),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .err       (err),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Region map of the default configuration, as a lookup table
  localparam logic [15:0] BASE [2] = '{16'hE000, 16'hB000};
  localparam logic [15:0] MASK [2] = '{16'hE000, 16'hF000};
  localparam int          WAITS[2] = '{2, 0};
  localparam bit          WRBL [2] = '{1'b0, 1'b1};

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  rdata;
    int          lat;
    logic        err;
    logic [15:0] eaddr;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   txn_no = 0;

  // Reference model state
  logic [7:0]  m_rdata = 8'h00;
  logic        m_err = 1'b0;
  logic [15:0] m_eaddr = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int find_region(input logic [15:0] a);
    for (int r = 0; r < 2; r++) begin
      if ((a & MASK[r]) == BASE[r]) return r;
    end
    return -1;
  endfunction

  // Monitor: every completion pops one expectation
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && cpu_ready) begin
      if (sbq.size() == 0) begin
        check("spurious_ready", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("rdata", 32'(cpu_rdata), 32'(mon_e.rdata));
        check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        check("err", 32'(err), 32'(mon_e.err));
        check("err_addr", 32'(err_addr), 32'(mon_e.eaddr));
        check("sel_cleared", 32'(mem_sel), 32'd0);
        $display("txn %0d addr=%h rdata=%h lat=%0d err=%b", txn_no, mon_e.addr, cpu_rdata,
                 cyc - mon_e.acc, err);
        txn_no++;
      end
      done_cnt++;
    end
  end

  task automatic do_txn(input logic [15:0] a, input logic w, input logic [7:0] wd,
                        input logic [15:0] rd, input logic inj);
    int r;
    int target;
    int guard;
    exp_t e;
    logic [1:0] esel;
    logic [1:0] ewe;
    @(negedge clk); #1;
    cpu_req   = 1'b1;
    cpu_we    = w;
    cpu_addr  = a;
    cpu_wdata = wd;
    mem_rdata = rd;
    r    = find_region(a);
    esel = (r < 0) ? 2'b00 : 2'(1 << r);
    ewe  = (w && r >= 0 && WRBL[r]) ? esel : 2'b00;
    if ((r < 0 || (w && !WRBL[r])) && !m_err) begin
      m_err   = 1'b1;
      m_eaddr = a;
    end
    if (!w) m_rdata = (r < 0) ? 8'h00 : rd[r*8 +: 8];
    e.addr  = a;
    e.rdata = m_rdata;
    e.lat   = ((r < 0) ? 0 : WAITS[r]) + 1;
    e.err   = m_err;
    e.eaddr = m_eaddr;
    e.acc   = cyc + 1;
    sbq.push_back(e);
    target = done_cnt + 1;
    @(negedge clk); #1;
    check("mem_sel", 32'(mem_sel), 32'(esel));
    check("mem_we", 32'(mem_we), 32'(ewe));
    check("mem_addr", 32'(mem_addr), 32'(a));
    check("mem_wdata", 32'(mem_wdata), 32'(wd));
    // Optionally pulse a competing request while busy; it must be dropped
    cpu_req = inj;
    if (inj) begin
      cpu_addr = 16'($urandom);
      cpu_we   = 1'($urandom);
    end
    @(negedge clk); #1;
    cpu_req = 1'b0;
    check("we_one_cycle", 32'(mem_we), 32'd0);
    check("addr_hold", 32'(mem_addr), 32'(a));
    guard = 0;
    while (done_cnt < target && guard < 60) begin
      @(negedge clk); #1;
      guard++;
    end
    if (done_cnt < target) check("timeout", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    logic [15:0] a;
    int sel;
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    mem_rdata = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_sel", 32'(mem_sel), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    do_txn(16'hE123, 1'b0, 8'h00, 16'h335A, 1'b0);
    do_txn(16'hB010, 1'b1, 8'h41, 16'h1111, 1'b0);
    do_txn(16'h1234, 1'b0, 8'h00, 16'hFFFF, 1'b0);
    do_txn(16'h2000, 1'b0, 8'h00, 16'hFFFF, 1'b0);
    do_txn(16'hF000, 1'b1, 8'h99, 16'h2222, 1'b0);
    do_txn(16'hE000, 1'b0, 8'h00, 16'h77C3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0:       a = 16'($urandom);
        1:       a = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
        2:       a = 16'hB000 | 16'($urandom_range(0, 16'h0FFF));
        default: a = 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
      endcase
      do_txn(a, 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom));
    end

    // Reset one cycle into a 2-wait read: everything clears at once
    @(negedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'hE000;
    @(negedge clk); #1;
    cpu_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(cpu_ready), 32'd0);
    check("arst_rdata", 32'(cpu_rdata), 32'd0);
    check("arst_sel", 32'(mem_sel), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", 32'(mem_wdata), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_err_addr", 32'(err_addr), 32'd0);
    m_err   = 1'b0;
    m_eaddr = 16'h0000;
    m_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_txn(16'hE456, 1'b0, 8'h00, 16'h00A7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_txn(16'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 1'($urandom));
    end

    repeat (5) @(negedge clk);
    #1;
    check("queue_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_decoder.md
MEM_DECODER -- requirements
Module: mem_decoder

Interface
REQ-001 Parameter AW, default 16: CPU address width, in bits.
REQ-002 Parameter DW, default 8: data width, in bits.
REQ-003 Parameter NREG, default 2, range 1..8: number of decoded regions.
REQ-004 Parameter REG_BASE, default {16'hB000,16'hE000}: packed NREG*AW region base addresses; region 0 occupies the LSBs.
REQ-005 Parameter REG_MASK, default {16'hF000,16'hE000}: packed NREG*AW compare masks; an address matches region r when (addr & MASK[r]) == BASE[r].
REQ-006 Parameter REG_WAIT, default {4'd0,4'd2}: packed NREG*4 wait-state counts.
REQ-007 Parameter REG_WR, default 2'b10: per-region write-enable bits; a 1 means the region is writable.
REQ-008 Parameter DEF_DATA, default 8'h00: read data returned for unmapped accesses.
REQ-009 clk  in  1  sole clock; all state changes on its rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 cpu_req  in  1  access request, sampled in IDLE only.
REQ-012 cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
REQ-013 cpu_addr  in  AW  access address.
REQ-014 cpu_wdata  in  DW  write data.
REQ-015 cpu_rdata  out  DW  read data; registered and held until the next completion.
REQ-016 cpu_ready  out  1  one-cycle completion pulse.
REQ-017 mem_addr  out  AW  latched address.
REQ-018 mem_wdata  out  DW  latched write data.
REQ-019 mem_sel  out  NREG  one-hot region select.
REQ-020 mem_we  out  NREG  per-region write strobe.
REQ-021 mem_rdata  in  NREG*DW  read data from each region; region 0 occupies the LSBs.
REQ-022 err  out  1  sticky fault flag.
REQ-023 err_addr  out  AW  address of the first fault.

Function
REQ-024 The FSM SHALL have states IDLE and BUSY.
REQ-025 In IDLE, when cpu_req=1, the block SHALL decode cpu_addr; if several regions match, the lowest index SHALL win.
REQ-026 On accept (edge E0), the block SHALL latch mem_addr and mem_wdata, set mem_sel to the winning region (all zero if unmapped), load cnt with REG_WAIT[r] (0 if unmapped), and enter BUSY.
REQ-027 mem_we[r] SHALL be high for exactly one cycle (E0 to E1) when the access is a write, the address is mapped, and REG_WR[r]=1; otherwise mem_we SHALL stay 0.
REQ-028 In BUSY with cnt≠0, the block SHALL decrement cnt each cycle.
REQ-029 In BUSY with cnt=0, the next edge (E(W+1)) SHALL capture cpu_rdata, pulse cpu_ready for one cycle, clear mem_sel, and return to IDLE.
REQ-030 Captured read data SHALL be mem_rdata slice r for mapped reads, DEF_DATA for unmapped reads, and SHALL be left unchanged for writes.
REQ-031 Request-to-ready latency SHALL be REG_WAIT[r]+1 cycles, so a memory with read latency L requires REG_WAIT ≥ L-1.
REQ-032 cpu_req SHALL be ignored while BUSY; it is not queued.
REQ-033 The earliest back-to-back acceptance SHALL be the cycle after cpu_ready.
REQ-034 mem_addr and mem_wdata SHALL hold their values from E0 until the next accept.
REQ-035 A fault is an unmapped access, or a write to a region with REG_WR=0.
REQ-036 A fault SHALL still complete with normal timing.
REQ-037 The first fault SHALL set err and latch err_addr; later faults SHALL not change err_addr.
REQ-038 err SHALL clear only on reset.
REQ-039 cnt SHALL be 4 bits wide; REG_WAIT=15 yields a 16-cycle latency, with no wrap-around.

Reset
REQ-040 rst_n=0 SHALL immediately force state=IDLE, cnt=0, cpu_ready=0, cpu_rdata=0, mem_sel=0, mem_we=0, mem_addr=0, mem_wdata=0, err=0, and err_addr=0, including when reset occurs mid-BUSY.
REQ-041 A transaction aborted by reset SHALL produce no cpu_ready and no further mem_we.
REQ-042 After rst_n rises, the first accept SHALL occur no earlier than the first clk edge on which rst_n=1.

Verification
REQ-043 Read E123 with mem_rdata slice 0 = 8'h5A -> mem_sel=01, cpu_ready high exactly 3 cycles after accept, cpu_rdata=5A, mem_we=00.
REQ-044 Write B010 with data 8'h41 -> mem_we=10 for exactly one cycle after accept, cpu_ready one cycle after accept, err=0.
REQ-045 Read 1234 (unmapped) -> mem_sel=00, cpu_rdata=00, cpu_ready after 1 cycle, err=1, err_addr=1234; a following read of 2000 leaves err_addr=1234.
REQ-046 Write F000 (read-only) -> mem_we=00, cpu_ready after 3 cycles, err=1.
REQ-047 Read E000, then pulse cpu_req with A=B000 during BUSY -> the second request is ignored and exactly one cpu_ready pulse occurs.
REQ-048 Assert rst_n=0 one cycle into a 2-wait read -> all outputs go to 0 asynchronously, no cpu_ready, and a new read after release completes normally.
